cpu_mem_responder: RTL and testbench

//  Memory-side responder for the multicycle CPU control FSM: services the CPU's

---
 rtl/mem_map_pkg.sv | 19 +
 rtl/mmio_regfile.sv | 44 ++++
 rtl/cpu_mem_responder.sv | 109 ++++++++++
 tb/tb_cpu_mem_responder.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_map_pkg.sv
// Shared memory map for the CPU memory responder: MMIO window base, register
// offsets and the responder state encoding.
package mem_map_pkg;

  localparam logic [15:0] DEF_IO_BASE = 16'hFF00;

  localparam logic [7:0] IO_IN     = 8'd0;
  localparam logic [7:0] IO_OUT    = 8'd1;
  localparam logic [7:0] TIMER     = 8'd2;
  localparam logic [7:0] TIMER_CLR = 8'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MEM  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } resp_state_t;

endpackage

// File: rtl/mmio_regfile.sv
// MMIO register file: switch synchroniser, LED output register, free-running
// cycle timer and the combinational read mux.
module mmio_regfile
  import mem_map_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] io_in,
  input  logic        wr_en,
  input  logic [7:0]  offset,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic [15:0] io_out
);

  logic [15:0] sync1, sync2, timer;

  always_ff @(posedge clock) begin
    if (!reset) begin
      sync1  <= '0;
      sync2  <= '0;
      io_out <= '0;
      timer  <= '0;
    end else begin
      sync1 <= io_in;
      sync2 <= sync1;
      if (wr_en && offset == IO_OUT) io_out <= wdata;
      // a clear landing on the same edge as an increment wins
      if (wr_en && offset == TIMER_CLR) timer <= '0;
      else                              timer <= timer + 16'd1;
    end
  end

  always_comb begin
    rdata = '0;
    case (offset)
      IO_IN:   rdata = sync2;
      IO_OUT:  rdata = io_out;
      TIMER:   rdata = timer;
      default: rdata = '0;
    endcase
  end

endmodule

// File: rtl/cpu_mem_responder.sv
// Memory-side responder for the multicycle CPU: req/ack handshake in front of
// a single-port synchronous BRAM and a small MMIO window.
module cpu_mem_responder
  import mem_map_pkg::*;
#(
  parameter int          MEM_AW     = 10,
  parameter int          RD_LATENCY = 1,
  parameter logic [15:0] IO_BASE    = DEF_IO_BASE
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [15:0]       cpu_addr,
  input  logic [15:0]       cpu_wdata,
  output logic [15:0]       cpu_rdata,
  output logic              cpu_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic [15:0]       mem_rdata,
  input  logic [15:0]       io_in,
  output logic [15:0]       io_out
);

  localparam logic [1:0] WAIT_LAST = 2'(RD_LATENCY - 1);

  resp_state_t state;
  logic        we_q;
  logic [1:0]  wait_cnt;

  logic        is_io, io_hit, io_wr;
  logic [15:0] io_rel, io_rdata;

  // offsets past the 256-word window read 0 and drop writes
  assign is_io  = cpu_addr >= IO_BASE;
  assign io_rel = cpu_addr - IO_BASE;
  assign io_hit = is_io && (io_rel[15:8] == 8'h00);
  assign io_wr  = (state == ST_IDLE) && cpu_req && io_hit && cpu_we;

  mmio_regfile u_mmio (
    .clock  (clock),
    .reset  (reset),
    .io_in  (io_in),
    .wr_en  (io_wr),
    .offset (io_rel[7:0]),
    .wdata  (cpu_wdata),
    .rdata  (io_rdata),
    .io_out (io_out)
  );

  // mem_addr/mem_wdata double as the request latches for RAM accesses
  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= ST_IDLE;
      cpu_ack   <= 1'b0;
      cpu_rdata <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      we_q      <= 1'b0;
      wait_cnt  <= '0;
    end else begin
      cpu_ack <= 1'b0;
      mem_en  <= 1'b0;
      mem_we  <= 1'b0;
      case (state)
        ST_IDLE: if (cpu_req) begin
          we_q <= cpu_we;
          if (is_io) begin
            state     <= ST_RESP;
            cpu_ack   <= 1'b1;
            cpu_rdata <= (cpu_we || !io_hit) ? 16'h0000 : io_rdata;
          end else begin
            state     <= ST_MEM;
            mem_en    <= 1'b1;
            mem_we    <= cpu_we;
            mem_addr  <= cpu_addr[MEM_AW-1:0];
            mem_wdata <= cpu_wdata;
          end
        end
        ST_MEM: begin
          wait_cnt <= '0;
          if (we_q) begin
            state     <= ST_RESP;
            cpu_ack   <= 1'b1;
            cpu_rdata <= '0;
          end else begin
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (wait_cnt == WAIT_LAST) begin
            state     <= ST_RESP;
            cpu_ack   <= 1'b1;
            cpu_rdata <= mem_rdata;
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Bench for cpu_mem_responder: two instances (read latency 1 and 3), each with
// a behavioural BRAM, checked against an array/arithmetic reference model.
module tb_cpu_mem_responder;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req       [2];
  logic        we        [2];
  logic [15:0] addr      [2];
  logic [15:0] wdata     [2];
  logic [15:0] rdata     [2];
  logic        ack       [2];
  logic        mem_en    [2];
  logic        mem_we    [2];
  logic [9:0]  mem_addr  [2];
  logic [15:0] mem_wdata [2];
  logic [15:0] mem_rdata [2];
  logic [15:0] io_in     [2];
  logic [15:0] io_out    [2];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int en_cnt [2];
  int ack_cnt[2];

  logic [15:0] ref_mem [2][1024];
  logic [15:0] io_out_ref [2];
  int          last_clr [2];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  always @(negedge clock)
    for (int g = 0; g < 2; g++) begin
      if (ack[g])    ack_cnt[g] <= ack_cnt[g] + 1;
      if (mem_en[g]) en_cnt[g]  <= en_cnt[g] + 1;
    end

  cpu_mem_responder #(.MEM_AW(10), .RD_LATENCY(1)) u_l1 (
    .clock(clock), .reset(reset), .cpu_req(req[0]), .cpu_we(we[0]),
    .cpu_addr(addr[0]), .cpu_wdata(wdata[0]), .cpu_rdata(rdata[0]), .cpu_ack(ack[0]),
    .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]), .io_in(io_in[0]), .io_out(io_out[0]));

  cpu_mem_responder #(.MEM_AW(10), .RD_LATENCY(3)) u_l3 (
    .clock(clock), .reset(reset), .cpu_req(req[1]), .cpu_we(we[1]),
    .cpu_addr(addr[1]), .cpu_wdata(wdata[1]), .cpu_rdata(rdata[1]), .cpu_ack(ack[1]),
    .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]), .io_in(io_in[1]), .io_out(io_out[1]));

  // synchronous BRAM with a LAT-deep output pipeline
  for (genvar g = 0; g < 2; g++) begin : g_bram
    localparam int LAT = (g == 0) ? 1 : 3;
    logic [15:0] ram  [1024];
    logic [15:0] pipe [LAT];
    initial begin
      for (int i = 0; i < 1024; i++) ram[i] = '0;
      for (int i = 0; i < LAT; i++) pipe[i] = '0;
    end
    always @(posedge clock) begin
      if (mem_en[g]) begin
        if (mem_we[g]) ram[mem_addr[g]] <= mem_wdata[g];
        pipe[0] <= ram[mem_addr[g]];
      end
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign mem_rdata[g] = pipe[LAT-1];
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic chk_zero(input string tag);
    for (int g = 0; g < 2; g++)
      chk(tag, {rdata[g], io_out[g], mem_wdata[g], mem_addr[g], ack[g], mem_en[g], mem_we[g]}, 64'd0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    for (int g = 0; g < 2; g++) req[g] = 1'b0;
    idle(3);
    chk_zero("rst_outs");
    reset = 1'b1;
    for (int g = 0; g < 2; g++) begin last_clr[g] = cyc; io_out_ref[g] = '0; end
  endtask

  // one complete request; expected result derived from the model before issue
  task automatic access(input int g, input logic w, input logic [15:0] a,
                        input logic [15:0] d, input string tag);
    int lat, e0, en0, ak0, exp_lat;
    logic [15:0] exp, off;
    logic io;
    io  = (a >= 16'hFF00);
    off = a - 16'hFF00;
    e0  = cyc + 1;
    en0 = en_cnt[g];
    ak0 = ack_cnt[g];
    exp = '0;
    if (io) begin
      exp_lat = 1;
      if (!w)
        case (off)
          16'd0:   exp = io_in[g];
          16'd1:   exp = io_out_ref[g];
          16'd2:   exp = 16'(e0 - 1 - last_clr[g]);
          default: exp = '0;
        endcase
    end else begin
      exp_lat = w ? 2 : (((g == 0) ? 1 : 3) + 2);
      if (!w) exp = ref_mem[g][a[9:0]];
    end
    req[g] = 1'b1; we[g] = w; addr[g] = a; wdata[g] = d;
    lat = 0;
    do begin @(posedge clock); #1; lat++; end while (!ack[g] && lat < 20);
    req[g] = 1'b0;
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_rdata"}, rdata[g], exp);
    if (w) begin
      if (!io)            ref_mem[g][a[9:0]] = d;
      else if (off == 1)  io_out_ref[g] = d;
      else if (off == 3)  last_clr[g] = e0;
    end
    chk({tag, "_io_out"}, io_out[g], io_out_ref[g]);
    @(posedge clock); #1;
    chk({tag, "_hold"}, rdata[g], exp);
    chk({tag, "_en"}, en_cnt[g] - en0, io ? 0 : 1);
    chk({tag, "_acks"}, ack_cnt[g] - ak0, 1);
  endtask

  // store then load with cpu_req held high across the first ack
  task automatic b2b(input int g);
    int lat, en0, ak0;
    logic [15:0] a, d;
    a = 16'h0100 + 16'(g); d = 16'($urandom);
    en0 = en_cnt[g]; ak0 = ack_cnt[g];
    req[g] = 1'b1; we[g] = 1'b1; addr[g] = a; wdata[g] = d;
    lat = 0;
    do begin @(posedge clock); #1; lat++; end while (!ack[g] && lat < 20);
    chk("b2b_st_lat", lat, 2);
    we[g] = 1'b0;
    lat = 0;
    do begin @(posedge clock); #1; lat++; end while (!ack[g] && lat < 20);
    req[g] = 1'b0;
    chk("b2b_ld_lat", lat, 1 + ((g == 0) ? 1 : 3) + 2);
    chk("b2b_ld_rdata", rdata[g], d);
    ref_mem[g][a[9:0]] = d;
    @(posedge clock); #1;
    chk("b2b_en", en_cnt[g] - en0, 2);
    chk("b2b_acks", ack_cnt[g] - ak0, 2);
  endtask

  task automatic abort_test();
    int ak0, en1;
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 16'h0012;
    @(posedge clock); #1;
    ak0 = ack_cnt[0]; en1 = en_cnt[1];
    req[0] = 1'b0; reset = 1'b0;
    req[1] = 1'b1; we[1] = 1'b1; addr[1] = 16'h0033; wdata[1] = 16'hDEAD;
    idle(3);
    req[1] = 1'b0;
    chk("abort_no_ack", ack_cnt[0] - ak0, 0);
    chk("abort_no_wr", en_cnt[1] - en1, 0);
    chk_zero("abort_outs");
    reset = 1'b1;
    for (int g = 0; g < 2; g++) begin last_clr[g] = cyc; io_out_ref[g] = '0; end
    idle(3);
    access(1, 1'b0, 16'h0033, 16'h0, "abort_mem");
    access(0, 1'b0, 16'h0012, 16'h0, "abort_rd");
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  initial begin
    for (int g = 0; g < 2; g++) begin
      req[g] = 0; we[g] = 0; addr[g] = 0; wdata[g] = 0; io_in[g] = 0;
      en_cnt[g] = 0; ack_cnt[g] = 0; io_out_ref[g] = 0; last_clr[g] = 0;
      for (int i = 0; i < 1024; i++) ref_mem[g][i] = '0;
    end
    #1;
    do_reset();

    for (int g = 0; g < 2; g++) begin
      access(g, 1'b1, 16'h0012, 16'hBEEF, "st");
      access(g, 1'b0, 16'h0012, 16'h0, "ld");
    end
    access(0, 1'b1, 16'h0405, 16'h1234, "al_st");
    access(0, 1'b0, 16'h0005, 16'h0, "al_ld");
    chk("al_val", rdata[0], 16'h1234);

    for (int g = 0; g < 2; g++) begin
      io_in[g] = 16'hA5A5;
      idle(2);
      access(g, 1'b0, 16'hFF00, 16'h0, "io_in");
      access(g, 1'b1, 16'hFF01, 16'h00FF, "io_wr");
      access(g, 1'b0, 16'hFF01, 16'h0, "io_rd");
      access(g, 1'b0, 16'hFF07, 16'h0, "io_oth");
      access(g, 1'b1, 16'hFF00, 16'h1111, "ro_wr");
      access(g, 1'b0, 16'hFF00, 16'h0, "ro_rd");
      access(g, 1'b1, 16'hFF03, 16'h5555, "tclr");
      idle(10);
      access(g, 1'b0, 16'hFF02, 16'h0, "tmr");
      chk("tmr_known", rdata[g], 16'd11);
    end

    abort_test();
    b2b(0);
    b2b(1);

    for (int n = 0; n < 250; n++)
      for (int g = 0; g < 2; g++) begin
        int k;
        logic [15:0] a;
        k = $urandom_range(0, 9);
        a = 16'($urandom_range(0, 63) | ($urandom_range(0, 63) << 10));
        if (k < 4)       access(g, 1'b1, a, 16'($urandom), "r_st");
        else if (k < 8)  access(g, 1'b0, a, 16'h0, "r_ld");
        else if (k == 8) begin
          io_in[g] = 16'($urandom);
          idle(2);
          access(g, 1'b0, 16'hFF00, 16'h0, "r_io_in");
        end else
          access(g, 1'($urandom_range(0, 1)), 16'hFF00 + 16'($urandom_range(0, 7)),
                 16'($urandom), "r_mmio");
      end

    access(0, 1'b1, 16'hFF03, 16'h0, "wrap_clr");
    while (cyc < last_clr[0] + 65540) begin @(posedge clock); #1; end
    access(0, 1'b0, 16'hFF02, 16'h0, "wrap");
    chk("wrap_small", rdata[0] < 16'd16, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
